// File: rtl/sram_ctrl_logic.sv
// Switch/button front end for an async cellular RAM, 8-bit path.
// Optional rd_data readback register: define READBACK_LATCH_EN.
module sram_ctrl_logic #(
  parameter int WAIT_CYCLES = 7,
  parameter int ADDR_W      = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        switches,
  input  logic              write,
  input  logic              read,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        databus,
  output logic              ce,
  output logic              we,
  output logic              oe,
  output logic              sram_clk,
  output logic              adv,
  output logic              cre,
  output logic              lb,
  output logic              ub
`ifdef READBACK_LATCH_EN
  ,
  output logic [7:0]        rd_data
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_SETUP = 3'd1;
  localparam logic [2:0] WR_PULSE = 3'd2;
  localparam logic [2:0] WR_HOLD  = 3'd3;
  localparam logic [2:0] RD_SETUP = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] RD_END   = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        data_q;
  logic              write_q;
  logic              read_q;
  logic              wr_edge;
  logic              rd_edge;
  logic              drive;

  assign wr_edge = write & ~write_q;
  assign rd_edge = read & ~read_q;

  // Previous-cycle copies of the request levels for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      write_q <= write;
      read_q  <= read;
    end
  end

  // Access sequencer: setup, timed strobe, hold, then a dead cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      addr   <= '0;
      data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (wr_edge) begin
            state  <= WR_SETUP;
            data_q <= switches;
            addr   <= wr_ptr;
          end else if (rd_edge) begin
            state <= RD_SETUP;
            addr  <= {{(ADDR_W-8){1'b0}}, switches};
          end
        end
        WR_SETUP: begin
          cnt   <= '0;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= WR_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_HOLD: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= DONE;
        end
        RD_SETUP: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RD_END;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_END: state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef READBACK_LATCH_EN
  // Capture the SRAM byte on the last cycle oe is held low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (state == RD_WAIT && cnt == LAST) begin
      rd_data <= databus;
    end
  end
`endif

  // Strobes decode straight from state so reset releases them at once
  always_comb begin
    ce    = 1'b1;
    we    = 1'b1;
    oe    = 1'b1;
    drive = 1'b0;
    unique case (state)
      WR_SETUP: begin
        ce    = 1'b0;
        drive = 1'b1;
      end
      WR_PULSE: begin
        ce    = 1'b0;
        we    = 1'b0;
        drive = 1'b1;
      end
      WR_HOLD: begin
        ce    = 1'b0;
        drive = 1'b1;
      end
      RD_SETUP: ce = 1'b0;
      RD_WAIT: begin
        ce = 1'b0;
        oe = 1'b0;
      end
      default: ;
    endcase
  end

  assign databus  = drive ? data_q : 8'hzz;
  assign sram_clk = 1'b0;
  assign adv      = 1'b0;
  assign cre      = 1'b0;
  assign lb       = 1'b0;
  assign ub       = 1'b1;

endmodule

// File: tb/tb_sram_ctrl_logic.sv
// Directed bench for sram_ctrl_logic with a tiny async SRAM model.
// Build with +define+READBACK_LATCH_EN to also check rd_data.
module tb_sram_ctrl_logic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  switches = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [22:0] addr;
  wire  [7:0]  databus;
  logic        ce, we, oe;
  logic        sram_clk, adv, cre, lb, ub;
`ifdef READBACK_LATCH_EN
  logic [7:0]  rd_data;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] mem [0:15];
  logic [7:0] zb;

  always #5 clk = ~clk;

  sram_ctrl_logic dut (
    .clk(clk), .rst(rst), .switches(switches),
    .write(write), .read(read), .addr(addr),
    .databus(databus), .ce(ce), .we(we), .oe(oe),
    .sram_clk(sram_clk), .adv(adv), .cre(cre),
    .lb(lb), .ub(ub)
`ifdef READBACK_LATCH_EN
    , .rd_data(rd_data)
`endif
  );

  assign databus = (!ce && !oe) ? mem[addr[3:0]] : 8'hzz;

  always @(posedge clk)
    if (!ce && !we) mem[addr[3:0]] <= databus;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  int         we_lo, oe_lo, falls, bad;
  logic [7:0] bus_w, bus_r;
  logic [22:0] a_seen;

  // Run one request for 24 cycles; w/r held 10 cycles.
  // retrig drops write for one cycle mid-pulse.
  task automatic op(input logic w, input logic r,
                    input logic [7:0] sw, input logic retrig);
    logic pwe;
    we_lo = 0; oe_lo = 0; falls = 0; bad = 0;
    bus_w = 'x; bus_r = 'x; a_seen = 'x;
    pwe = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      switches = sw;
      write = w && i < 10 && !(retrig && i == 3);
      read  = r && i < 10;
      @(negedge clk);
      if (!we) begin
        we_lo++;
        bus_w = databus;
      end
      if (pwe && !we) falls++;
      pwe = we;
      if (!oe) begin
        oe_lo++;
        bus_r = databus;
        if (databus !== mem[addr[3:0]]) bad++;
      end
      if (!ce) a_seen = addr;
      if (!we && !oe) bad++;
    end
  endtask

  task automatic do_write(input logic [7:0] d,
                          input logic [22:0] a);
    op(1'b1, 1'b0, d, 1'b0);
    check("wr_we_cycles", we_lo, 7);
    check("wr_count", falls, 1);
    check("wr_addr", {9'd0, a_seen}, {9'd0, a});
    check("wr_data", {24'd0, bus_w}, {24'd0, d});
  endtask

  task automatic do_read(input logic [7:0] a,
                         input logic [7:0] d);
    op(1'b0, 1'b1, a, 1'b0);
    check("rd_oe_cycles", oe_lo, 7);
    check("rd_we_idle", falls, 0);
    check("rd_addr", {9'd0, a_seen}, {24'd0, a});
    check("rd_data_bus", {24'd0, bus_r}, {24'd0, d});
`ifdef READBACK_LATCH_EN
    check("rd_data_reg", {24'd0, rd_data}, {24'd0, d});
`endif
  endtask

  initial begin
    zb = 8'hzz;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #100;
    check("rst_ce", {31'd0, ce}, 1);
    check("rst_we", {31'd0, we}, 1);
    check("rst_oe", {31'd0, oe}, 1);
    check("rst_bus", {24'd0, databus}, {24'd0, zb});
    check("rst_addr", {9'd0, addr}, 0);
    check("tie_lo", {28'd0, sram_clk, adv, cre, lb}, 0);
    check("tie_ub", {31'd0, ub}, 1);
`ifdef READBACK_LATCH_EN
    check("rst_rd_data", {24'd0, rd_data}, 0);
`endif
    @(negedge clk); rst = 1'b0;

    do_write(8'hFF, 23'd0);
    do_write(8'h80, 23'd1);
    do_write(8'h40, 23'd2);
    do_write(8'h20, 23'd3);
    check("mem3", {24'd0, mem[3]}, 32'h20);

    do_read(8'd0, 8'hFF);
    do_read(8'd1, 8'h80);
    do_read(8'd2, 8'h40);
    do_read(8'd3, 8'h20);

    op(1'b1, 1'b1, 8'h55, 1'b0);
    check("both_oe_hi", oe_lo, 0);
    check("both_wr", falls, 1);
    check("both_addr", {9'd0, a_seen}, 4);

    op(1'b1, 1'b0, 8'h66, 1'b1);
    check("retrig_count", falls, 1);
    check("retrig_addr", {9'd0, a_seen}, 5);
    do_write(8'h77, 23'd6);
    check("no_bus_clash", bad, 0);

    @(posedge clk); #1;
    switches = 8'h99; write = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_we", {31'd0, we}, 0);
    rst = 1'b1; #1;
    check("abort_we", {31'd0, we}, 1);
    check("abort_ce", {31'd0, ce}, 1);
    check("abort_bus", {24'd0, databus}, {24'd0, zb});
    @(negedge clk);
    write = 1'b0; rst = 1'b0;
    do_write(8'h33, 23'd0);
    do_read(8'd0, 8'h33);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_logic.md
Name: sram_ctrl_logic

Overview:
- Control block between board switches/buttons and an asynchronous external SRAM (cellular RAM used in async mode, 8-bit data path).
- A write request stores the switch value at the next sequential SRAM address.
- A read request fetches the byte at the address given by the switches and drives the SRAM control pins with correct async timing.

Parameters:
- WAIT_CYCLES, 7, clock cycles ce/we or ce/oe held active per access (7 x 10 ns = 70 ns at 100 MHz).
- ADDR_W, 23, SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- switches  in  8  write data (write op) or read address (read op).
- write  in  1  write request, level held for several cycles; rising edge triggers one write.
- read  in  1  read request; rising edge triggers one read.
- addr  out  23  SRAM address.
- databus  inout  8  SRAM data; driven only during write states, else high-Z.
- ce  out  1  chip enable, active low.
- we  out  1  write enable, active low.
- oe  out  1  output enable, active low.
- sram_clk  out  1  tied 0 (async mode).
- adv  out  1  tied 0.
- cre  out  1  tied 0.
- lb  out  1  tied 0 (lower byte enabled).
- ub  out  1  tied 1 (upper byte disabled).

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ce=we=oe=1; databus=Z; addr=0; write-address counter wr_ptr=0; edge-detect registers cleared.
- Edge detection: write and read registered each cycle; request = input 1 now and 0 previous cycle. A held-high level triggers only once.
- IDLE: ce=we=oe=1, databus Z, addr holds last value.
  - Write edge -> WR_SETUP; latch data=switches; addr=wr_ptr.
  - Read edge -> RD_SETUP; addr={15'b0, switches}.
  - Simultaneous write and read edges: write wins; read edge dropped.
- WR_SETUP (1 cycle): ce=0, we=1, databus driven with latched data -> WR_PULSE.
- WR_PULSE (WAIT_CYCLES cycles): ce=0, we=0, databus driven -> WR_HOLD.
- WR_HOLD (1 cycle): we=1, ce=0, databus still driven (data hold). wr_ptr increments (mod 2^ADDR_W, wraps to 0) -> DONE.
- RD_SETUP (1 cycle): ce=0, oe=1, databus Z -> RD_WAIT.
- RD_WAIT (WAIT_CYCLES cycles): ce=0, oe=0 -> RD_END.
  - On the final cycle, databus is sampled into the internal read register.
- RD_END (1 cycle): ce=1, oe=1 -> DONE.
- DONE (1 cycle): all strobes inactive -> IDLE.
- Edges arriving outside IDLE are ignored and not queued.
- Total write latency: WAIT_CYCLES+3 cycles. Total read latency: WAIT_CYCLES+3 cycles (both from edge detection to IDLE).
- we and oe never low simultaneously.
- databus never driven while oe=0.
- Reset mid-operation aborts immediately: strobes high, bus released, wr_ptr=0.

Optional Feature:
- Macro READBACK_LATCH_EN.
- Defined: adds output port rd_data[7:0].
  - Reset value 0.
  - Updated with the byte sampled at the end of RD_WAIT.
  - Holds until the next read completes.
- Undefined: no rd_data port. The sampled byte is only visible on databus while oe=0. No sampling register is synthesized.

Test Plan:
- Reset held 100 ns -> ce=we=oe=1, databus Z, addr=0, sram_clk=adv=cre=lb=0, ub=1.
- switches=255, write high 100 ns -> exactly one write at addr 0, databus=0xFF while we=0; we low for 7 cycles; wr_ptr becomes 1.
- Then writes of 128, 64, 32, each a 100 ns pulse -> SRAM addresses 1, 2, 3 hold 0x80, 0x40, 0x20.
- read with switches=0,1,2,3 -> addr=0..3, oe low 7 cycles, databus reads 0xFF, 0x80, 0x40, 0x20; rd_data matches when READBACK_LATCH_EN is defined.
- write and read rising on the same cycle -> only the write occurs; oe stays 1 throughout. A second write edge during WR_PULSE is ignored.
- Assert rst during WR_PULSE -> we/ce go high asynchronously, databus Z, next write goes to addr 0.
